cache_axi_bridge: RTL and testbench

- Responder for the cache's memory-side request interface (rd_req/ret_* and wr_req/wr_rdy); acts as the master on an AXI bus.
- Converts each accepted cache read into one AR burst plus R beats returned as ret_*.
- Converts each accepted cache write into one AW burst, W beats and a B response.
- Sits between the cache and the AXI crossbar. It handles at most one read and one write in flight, and the read and write paths run independently.

---
 rtl/cache_axi_bridge.sv | 194 +++++++++++++++++++
 tb/tb_cache_axi_bridge.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_bridge.sv
// Cache memory-side responder acting as an AXI master: one read and one write in flight, independent paths.
// Optional build macro BRIDGE_RAW_CHECK_EN holds off reads that hit the 16-byte line of a write in flight.
module cache_axi_bridge #(
   parameter logic [3:0] RD_ID = 4'd0,
   parameter logic [3:0] WR_ID = 4'd1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         rd_req,
   input  logic [2:0]   rd_type,
   input  logic [31:0]  rd_addr,
   output logic         rd_rdy,
   output logic         ret_valid,
   output logic         ret_last,
   output logic [31:0]  ret_data,
   input  logic         wr_req,
   input  logic [2:0]   wr_type,
   input  logic [31:0]  wr_addr,
   input  logic [3:0]   wr_wstrb,
   input  logic [127:0] wr_data,
   output logic         wr_rdy,
   output logic [3:0]   arid,
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   output logic [2:0]   arsize,
   output logic         arvalid,
   input  logic         arready,
   input  logic [3:0]   rid,
   input  logic [31:0]  rdata,
   input  logic         rlast,
   input  logic         rvalid,
   output logic         rready,
   output logic [3:0]   awid,
   output logic [31:0]  awaddr,
   output logic [7:0]   awlen,
   output logic [2:0]   awsize,
   output logic         awvalid,
   input  logic         awready,
   output logic [31:0]  wdata,
   output logic [3:0]   wstrb,
   output logic         wlast,
   output logic         wvalid,
   input  logic         wready,
   input  logic         bvalid,
   output logic         bready
);

   typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

   // Line requests are four word beats; everything else is a single beat.
   function automatic logic [7:0] type_len(input logic [2:0] t);
      return (t == 3'd4) ? 8'd3 : 8'd0;
   endfunction

   function automatic logic [2:0] type_size(input logic [2:0] t);
      case (t)
         3'd0, 3'd1, 3'd2: return t;
         default:          return 3'd2;
      endcase
   endfunction

   r_state_t       r_state, r_next;
   w_state_t       w_state, w_next;
   logic [31:0]    ar_addr_q;
   logic [7:0]     ar_len_q;
   logic [2:0]     ar_size_q;
   logic [31:0]    aw_addr_q;
   logic [7:0]     aw_len_q;
   logic [2:0]     aw_size_q;
   logic [127:0]   w_buf_q;
   logic [3:0]     w_strb_q;
   logic           w_line_q;
   logic [1:0]     beat_q;
   logic           rd_accept, wr_accept, raw_block;
   logic           unused_rid;

   assign unused_rid = ^rid;

`ifdef BRIDGE_RAW_CHECK_EN
   assign raw_block = (w_state != W_IDLE) && (rd_addr[31:4] == aw_addr_q[31:4]);
`else
   assign raw_block = 1'b0;
`endif

   assign rd_accept = rd_req && rd_rdy;
   assign wr_accept = wr_req && wr_rdy;

   // Read path
   always_ff @(posedge clk) begin
      if (!resetn) r_state <= R_IDLE;
      else         r_state <= r_next;
   end

   always_ff @(posedge clk) begin
      if (rd_accept) begin
         ar_addr_q <= rd_addr;
         ar_len_q  <= type_len(rd_type);
         ar_size_q <= type_size(rd_type);
      end
   end

   always_comb begin
      r_next    = r_state;
      rd_rdy    = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      ret_valid = 1'b0;
      ret_last  = 1'b0;
      case (r_state)
         R_IDLE: begin
            rd_rdy = resetn && !raw_block;
            if (rd_req && rd_rdy) r_next = R_AR;
         end
         R_AR: begin
            arvalid = 1'b1;
            if (arready) r_next = R_DATA;
         end
         R_DATA: begin
            rready    = 1'b1;
            ret_valid = rvalid;
            ret_last  = rlast;
            if (rvalid && rlast) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign ret_data = rdata;
   assign arid     = RD_ID;
   assign araddr   = ar_addr_q;
   assign arlen    = ar_len_q;
   assign arsize   = ar_size_q;

   // Write path: AW, then W beats, then wait for B before accepting again
   always_ff @(posedge clk) begin
      if (!resetn) w_state <= W_IDLE;
      else         w_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!resetn)                                    beat_q <= 2'd0;
      else if (wr_accept)                             beat_q <= 2'd0;
      else if (w_state == W_DATA && wready && !wlast) beat_q <= beat_q + 2'd1;
   end

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         aw_addr_q <= wr_addr;
         aw_len_q  <= type_len(wr_type);
         aw_size_q <= type_size(wr_type);
         w_buf_q   <= wr_data;
         w_strb_q  <= wr_wstrb;
         w_line_q  <= (wr_type == 3'd4);
      end
   end

   always_comb begin
      w_next  = w_state;
      wr_rdy  = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      wlast   = 1'b0;
      bready  = 1'b0;
      case (w_state)
         W_IDLE: begin
            wr_rdy = resetn;
            if (wr_req && wr_rdy) w_next = W_AW;
         end
         W_AW: begin
            awvalid = 1'b1;
            if (awready) w_next = W_DATA;
         end
         W_DATA: begin
            wvalid = 1'b1;
            wlast  = ({6'd0, beat_q} == aw_len_q);
            if (wready && wlast) w_next = W_RESP;
         end
         W_RESP: begin
            bready = 1'b1;
            if (bvalid) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   assign awid   = WR_ID;
   assign awaddr = aw_addr_q;
   assign awlen  = aw_len_q;
   assign awsize = aw_size_q;
   assign wdata  = w_buf_q[{beat_q, 5'd0} +: 32];
   assign wstrb  = w_line_q ? 4'hf : w_strb_q;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: table of single transactions plus hand-written corner sequences.
module tb_cache_axi_bridge;

   logic         clk = 1'b0;
   logic         resetn;
   logic         rd_req;
   logic [2:0]   rd_type;
   logic [31:0]  rd_addr;
   logic         rd_rdy, ret_valid, ret_last;
   logic [31:0]  ret_data;
   logic         wr_req;
   logic [2:0]   wr_type;
   logic [31:0]  wr_addr;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic         arvalid, arready;
   logic [3:0]   rid;
   logic [31:0]  rdata;
   logic         rlast, rvalid, rready;
   logic [3:0]   awid;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic         awvalid, awready;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast, wvalid, wready, bvalid, bready;

   always #5 clk = ~clk;

   cache_axi_bridge dut (
      .clk(clk), .resetn(resetn),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
      .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
      .wr_data(wr_data), .wr_rdy(wr_rdy),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

`ifdef BRIDGE_RAW_CHECK_EN
   localparam logic RAW_RDY = 1'b0;
`else
   localparam logic RAW_RDY = 1'b1;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic         is_wr;
      logic [2:0]   typ;
      logic [31:0]  addr;
      logic [3:0]   strb;
      logic [127:0] wdat;
      logic [3:0][31:0] beats;
      int           ar_delay;
      logic         toggle;
      logic [7:0]   exp_len;
      logic [2:0]   exp_size;
      logic [3:0]   exp_strb;
   } vec_t;

   vec_t vecs[8];

   function automatic vec_t mk(input logic w, input logic [2:0] t, input logic [31:0] a,
                               input logic [3:0] s, input logic [127:0] d, input logic [127:0] b,
                               input int dl, input logic tg, input logic [7:0] l,
                               input logic [2:0] sz, input logic [3:0] es);
      vec_t v;
      v.is_wr = w; v.typ = t; v.addr = a; v.strb = s; v.wdat = d; v.beats = b;
      v.ar_delay = dl; v.toggle = tg; v.exp_len = l; v.exp_size = sz; v.exp_strb = es;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_read(input vec_t v);
      rd_req = 1'b1; rd_type = v.typ; rd_addr = v.addr;
      smp(); chk("rd_rdy_idle", rd_rdy, 1);
      step(); rd_req = 1'b0;
      for (int i = 0; i < v.ar_delay; i++) begin
         smp();
         chk("arvalid_stall", arvalid, 1);
         chk("araddr_stall", araddr, v.addr);
         chk("arsize_stall", arsize, v.exp_size);
         chk("rd_rdy_busy", rd_rdy, 0);
         step();
      end
      arready = 1'b1;
      smp();
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, v.addr);
      chk("arlen", arlen, v.exp_len);
      chk("arsize", arsize, v.exp_size);
      chk("arid", arid, 4'd0);
      chk("rready_in_ar", rready, 0);
      step(); arready = 1'b0;
      for (int k = 0; k <= int'(v.exp_len); k++) begin
         rvalid = 1'b1; rdata = v.beats[k]; rlast = (k == int'(v.exp_len));
         smp();
         chk("rready", rready, 1);
         chk("ret_valid", ret_valid, 1);
         chk("ret_data", ret_data, v.beats[k]);
         chk("ret_last", ret_last, (k == int'(v.exp_len)));
         step();
      end
      rvalid = 1'b0; rlast = 1'b0;
      smp();
      chk("rd_rdy_after", rd_rdy, 1);
      chk("rready_after", rready, 0);
      step();
   endtask

   task automatic do_write(input vec_t v);
      wr_req = 1'b1; wr_type = v.typ; wr_addr = v.addr; wr_wstrb = v.strb; wr_data = v.wdat;
      smp(); chk("wr_rdy_idle", wr_rdy, 1);
      step(); wr_req = 1'b0;
      smp();
      chk("awvalid_stall", awvalid, 1);
      chk("wr_rdy_busy", wr_rdy, 0);
      chk("wvalid_in_aw", wvalid, 0);
      step();
      awready = 1'b1;
      smp();
      chk("awvalid", awvalid, 1);
      chk("awaddr", awaddr, v.addr);
      chk("awlen", awlen, v.exp_len);
      chk("awsize", awsize, v.exp_size);
      chk("awid", awid, 4'd1);
      step(); awready = 1'b0;
      for (int k = 0; k <= int'(v.exp_len); k++) begin
         wready = 1'b1;
         smp();
         chk("wvalid", wvalid, 1);
         chk("wdata", wdata, v.beats[k]);
         chk("wstrb", wstrb, v.exp_strb);
         chk("wlast", wlast, (k == int'(v.exp_len)));
         step();
         if (v.toggle && k < int'(v.exp_len)) begin
            wready = 1'b0;
            smp();
            chk("wvalid_hold", wvalid, 1);
            chk("wdata_hold", wdata, v.beats[k+1]);
            chk("wlast_hold", wlast, (k + 1 == int'(v.exp_len)));
            step();
         end
      end
      wready = 1'b0;
      smp();
      chk("bready", bready, 1);
      chk("wvalid_in_b", wvalid, 0);
      chk("wr_rdy_in_b", wr_rdy, 0);
      step();
      bvalid = 1'b1;
      smp();
      chk("wr_rdy_bvalid", wr_rdy, 0);
      step(); bvalid = 1'b0;
      smp();
      chk("wr_rdy_after", wr_rdy, 1);
      chk("bready_after", bready, 0);
      step();
   endtask

   task automatic slave_reset();
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      rd_req = 1'b0; rd_type = '0; rd_addr = '0;
      wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
      slave_reset();

      vecs[0] = mk(0, 3'd4, 32'h1C000010, 4'h0, 128'h0,
                   {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, 8'd3, 3'd2, 4'h0);
      vecs[1] = mk(1, 3'd2, 32'h00000080, 4'h3, 128'hDEADBEEF, 128'hDEADBEEF, 0, 0, 8'd0, 3'd2, 4'h3);
      vecs[2] = mk(1, 3'd4, 32'h00000100, 4'h0, {32'h4, 32'h3, 32'h2, 32'h1},
                   {32'h4, 32'h3, 32'h2, 32'h1}, 0, 1, 8'd3, 3'd2, 4'hf);
      vecs[3] = mk(0, 3'd0, 32'h00000103, 4'h0, 128'h0, 128'hAB, 5, 0, 8'd0, 3'd0, 4'h0);
      vecs[4] = mk(0, 3'd1, 32'h00000202, 4'h0, 128'h0, 128'hBEEF, 0, 0, 8'd0, 3'd1, 4'h0);
      vecs[5] = mk(1, 3'd0, 32'h00000041, 4'h2, 128'h5A00, 128'h5A00, 0, 0, 8'd0, 3'd0, 4'h2);
      vecs[6] = mk(0, 3'd7, 32'h00000044, 4'h0, 128'h0, 128'h12345678, 0, 0, 8'd0, 3'd2, 4'h0);
      vecs[7] = mk(1, 3'd3, 32'h00000048, 4'hC, 128'hCAFE0000, 128'hCAFE0000, 0, 0, 8'd0, 3'd2, 4'hC);

      // Reset state
      step(); step();
      smp();
      chk("rst_rd_rdy", rd_rdy, 0);
      chk("rst_wr_rdy", wr_rdy, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_wlast", wlast, 0);
      chk("rst_bready", bready, 0);
      chk("rst_rready", rready, 0);
      step();
      resetn = 1'b1;
      smp();
      chk("rel_rd_rdy", rd_rdy, 1);
      chk("rel_wr_rdy", wr_rdy, 1);
      step();

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].is_wr) do_write(vecs[i]);
         else               do_read(vecs[i]);
      end

      // Concurrent line write and word read accepted in the same cycle
      rd_req = 1'b1; rd_type = 3'd2; rd_addr = 32'h300;
      wr_req = 1'b1; wr_type = 3'd4; wr_addr = 32'h200; wr_wstrb = 4'h0;
      wr_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      smp();
      chk("cc_rd_rdy", rd_rdy, 1);
      chk("cc_wr_rdy", wr_rdy, 1);
      step(); rd_req = 1'b0; wr_req = 1'b0;
      arready = 1'b1;
      smp();
      chk("cc_arvalid", arvalid, 1);
      chk("cc_awvalid", awvalid, 1);
      chk("cc_araddr", araddr, 32'h300);
      chk("cc_awaddr", awaddr, 32'h200);
      chk("cc_awlen", awlen, 8'd3);
      step();
      arready = 1'b0; awready = 1'b1; rvalid = 1'b1; rdata = 32'h77; rlast = 1'b1;
      smp();
      chk("cc_ret_valid", ret_valid, 1);
      chk("cc_ret_data", ret_data, 32'h77);
      chk("cc_awvalid2", awvalid, 1);
      chk("cc_arvalid2", arvalid, 0);
      step();
      awready = 1'b0; rvalid = 1'b0; rlast = 1'b0; wready = 1'b1;
      smp();
      chk("cc_rd_rdy_wbusy", rd_rdy, 1);
      chk("cc_wdata0", wdata, 32'hA0);
      step();
      smp(); chk("cc_wdata1", wdata, 32'hA1); step();
      smp(); chk("cc_wdata2", wdata, 32'hA2); step();
      smp();
      chk("cc_wdata3", wdata, 32'hA3);
      chk("cc_wlast", wlast, 1);
      step();
      wready = 1'b0; rd_addr = 32'h204;
      smp();
      chk("cc_bready", bready, 1);
      chk("raw_rd_rdy_resp", rd_rdy, RAW_RDY);
      step();
      bvalid = 1'b1;
      smp();
      chk("raw_rd_rdy_bvalid", rd_rdy, RAW_RDY);
      step(); bvalid = 1'b0;
      smp();
      chk("raw_rd_rdy_after", rd_rdy, 1);
      chk("cc_wr_rdy_after", wr_rdy, 1);
      step();
      rd_addr = 32'h0;

      // Reset while in R_DATA after two beats
      rd_req = 1'b1; rd_type = 3'd4; rd_addr = 32'h1C000020;
      smp(); step(); rd_req = 1'b0;
      arready = 1'b1;
      smp(); step(); arready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         rvalid = 1'b1; rdata = 32'h100 + k; rlast = 1'b0;
         smp(); chk("mid_ret_valid", ret_valid, 1); step();
      end
      rdata = 32'h102; resetn = 1'b0;
      step();
      slave_reset();
      smp();
      chk("mid_rready", rready, 0);
      chk("mid_arvalid", arvalid, 0);
      chk("mid_ret_valid_rst", ret_valid, 0);
      chk("mid_rd_rdy_rst", rd_rdy, 0);
      step();
      resetn = 1'b1;
      smp();
      chk("mid_rd_rdy_rel", rd_rdy, 1);
      chk("mid_rready_rel", rready, 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
